// File: rtl/memwrite_checker.sv
// memwrite_checker: compares CPU data-memory writes against a loadable table of expected (address, data) pairs.
// Latency: one cycle; a write sampled at edge k is reflected in the flags, match_count and err_* after edge k.
// Backpressure: none; pure monitor, every memwrite cycle in ARMED is consumed and checked the same cycle.
//
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   exp_we, exp_adr, exp_data         append an expected write to the table (ignored while armed)
//   exp_clr                           empty the table (wins over exp_we)
//   start                             arm the checker if the table is non-empty
//   memwrite, dataadr, writedata      CPU write port being monitored
//   pass, fail, timeout, done, armed  sticky result flags and state indication
//   match_count                       expected entries matched so far
//   err_adr, err_data                 offending write captured on fail
module memwrite_checker #(
   parameter int               WIDTH      = 32,
   parameter int               DEPTH      = 4,
   parameter int               TIMEOUT    = 90,
   parameter bit               IGNORE_EN  = 1'b1,
   parameter logic [WIDTH-1:0] IGNORE_ADR = WIDTH'(80),
   parameter int               MODE       = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       exp_we,
   input  logic [WIDTH-1:0]           exp_adr,
   input  logic [WIDTH-1:0]           exp_data,
   input  logic                       exp_clr,
   input  logic                       start,
   input  logic                       memwrite,
   input  logic [WIDTH-1:0]           dataadr,
   input  logic [WIDTH-1:0]           writedata,
   output logic                       pass,
   output logic                       fail,
   output logic                       timeout,
   output logic                       done,
   output logic                       armed,
   output logic [$clog2(DEPTH+1)-1:0] match_count,
   output logic [WIDTH-1:0]           err_adr,
   output logic [WIDTH-1:0]           err_data
);

   localparam int CW = $clog2(DEPTH+1);
   // Timer is sized to hold TIMEOUT; a zero TIMEOUT still needs a legal 1-bit vector.
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
   localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT-1) : '0;
   localparam logic [TW-1:0] TMAX  = '1;

   // One-hot-style encoding so every result flag is a state flop bit directly.
   typedef enum logic [3:0] {
      S_IDLE  = 4'b0000,
      S_ARMED = 4'b0001,
      S_PASS  = 4'b0010,
      S_FAIL  = 4'b0100,
      S_TMO   = 4'b1000
   } state_t;

   state_t           state, state_nxt;

   logic [WIDTH-1:0] tbl_adr [DEPTH];
   logic [WIDTH-1:0] tbl_dat [DEPTH];
   logic [CW-1:0]    wr_ptr;
   logic [CW-1:0]    mcnt;
   logic [TW-1:0]    timer;
   logic [WIDTH-1:0] err_adr_q, err_dat_q;

   logic [WIDTH-1:0] cur_adr, cur_dat;
   logic             armed_s, wr_chk, hit, last_hit, ign, miss, expire, go, tbl_wr_ok;

   // Entry currently awaited; a compare loop avoids an index wider than the table.
   always_comb begin
      cur_adr = '0;
      cur_dat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mcnt == CW'(i)) begin
            cur_adr = tbl_adr[i];
            cur_dat = tbl_dat[i];
         end
      end
   end

   always_comb begin
      armed_s   = (state == S_ARMED);
      wr_chk    = armed_s && memwrite;
      hit       = wr_chk && (dataadr == cur_adr) && (writedata == cur_dat);
      last_hit  = hit && (mcnt == wr_ptr - CW'(1));
      // Match is evaluated first, so an expected write to the ignore address still counts.
      ign       = IGNORE_EN && (dataadr == IGNORE_ADR);
      miss      = wr_chk && !hit && !ign && (MODE == 0);
      expire    = armed_s && (TIMEOUT > 0) && (timer == TLAST);
      // start in ARMED is ignored, so a write in the arming cycle is never checked.
      go        = start && !armed_s && (wr_ptr != '0);
      tbl_wr_ok = !armed_s && exp_we && !exp_clr && (wr_ptr != CW'(DEPTH));
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: completion outranks a coincident timer expiry.
   always_comb begin
      state_nxt = state;
      case (state)
         S_ARMED: begin
            if (last_hit)    state_nxt = S_PASS;
            else if (miss)   state_nxt = S_FAIL;
            else if (expire) state_nxt = S_TMO;
         end
         default: begin
            if (go) state_nxt = S_ARMED;
         end
      endcase
   end

   // Output decode (direct state flop bits)
   always_comb begin
      armed       = state[0];
      pass        = state[1];
      fail        = state[2];
      timeout     = state[3];
      done        = state[1] | state[2] | state[3];
      match_count = mcnt;
      err_adr     = err_adr_q;
      err_data    = err_dat_q;
   end

   // Table, match counter, timer and error capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_adr[i] <= '0;
            tbl_dat[i] <= '0;
         end
         wr_ptr    <= '0;
         mcnt      <= '0;
         timer     <= '0;
         err_adr_q <= '0;
         err_dat_q <= '0;
      end else begin
         if (!armed_s) begin
            if (exp_clr) begin
               wr_ptr <= '0;
            end else if (tbl_wr_ok) begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (wr_ptr == CW'(i)) begin
                     tbl_adr[i] <= exp_adr;
                     tbl_dat[i] <= exp_data;
                  end
               end
               wr_ptr <= wr_ptr + CW'(1);
            end
         end

         if (go) begin
            mcnt      <= '0;
            timer     <= '0;
            err_adr_q <= '0;
            err_dat_q <= '0;
         end else if (armed_s) begin
            if (hit) mcnt <= mcnt + CW'(1);
            if (miss) begin
               err_adr_q <= dataadr;
               err_dat_q <= writedata;
            end
            if (timer != TMAX) timer <= timer + TW'(1);
         end
      end
   end

endmodule

// File: tb/tb_memwrite_checker.sv
// tb_memwrite_checker: directed checks of memwrite_checker in strict and lenient configurations.
// Latency: expectations sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_memwrite_checker;

   logic        clk = 1'b0;
   logic        reset;
   logic        exp_we, exp_clr, start, memwrite;
   logic [31:0] exp_adr, exp_data, dataadr, writedata;

   // instance a: strict, TIMEOUT 90, ignore address 80
   logic        a_pass, a_fail, a_tmo, a_done, a_armed;
   logic [2:0]  a_mc;
   logic [31:0] a_eadr, a_edat;
   // instance b: lenient, TIMEOUT 6
   logic        b_pass, b_fail, b_tmo, b_done, b_armed;
   logic [2:0]  b_mc;
   logic [31:0] b_eadr, b_edat;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   memwrite_checker #(.WIDTH(32), .DEPTH(4), .TIMEOUT(90), .IGNORE_EN(1'b1),
                      .IGNORE_ADR(32'd80), .MODE(0)) u_a (
      .clk(clk), .reset(reset), .exp_we(exp_we), .exp_adr(exp_adr), .exp_data(exp_data),
      .exp_clr(exp_clr), .start(start), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .pass(a_pass), .fail(a_fail), .timeout(a_tmo), .done(a_done),
      .armed(a_armed), .match_count(a_mc), .err_adr(a_eadr), .err_data(a_edat));

   memwrite_checker #(.WIDTH(32), .DEPTH(4), .TIMEOUT(6), .IGNORE_EN(1'b1),
                      .IGNORE_ADR(32'd80), .MODE(1)) u_b (
      .clk(clk), .reset(reset), .exp_we(exp_we), .exp_adr(exp_adr), .exp_data(exp_data),
      .exp_clr(exp_clr), .start(start), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .pass(b_pass), .fail(b_fail), .timeout(b_tmo), .done(b_done),
      .armed(b_armed), .match_count(b_mc), .err_adr(b_eadr), .err_data(b_edat));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      exp_we = 1'b1; exp_adr = a; exp_data = d;
      step();
      exp_we = 1'b0;
   endtask

   task automatic clr();
      exp_clr = 1'b1;
      step();
      exp_clr = 1'b0;
   endtask

   task automatic arm();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      memwrite = 1'b1; dataadr = a; writedata = d;
      step();
      memwrite = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      exp_we = 1'b0; exp_clr = 1'b0; start = 1'b0; memwrite = 1'b0;
      exp_adr = '0; exp_data = '0; dataadr = '0; writedata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pass", a_pass, 0);
      chk("rst_fail", a_fail, 0);
      chk("rst_tmo", a_tmo, 0);
      chk("rst_armed", a_armed, 0);
      chk("rst_mc", a_mc, 0);
      chk("rst_eadr", a_eadr, 0);
      reset = 1'b0;

      // strict: ignored write to 80, then the expected write
      load(84, 7);
      arm();
      chk("t1_armed", a_armed, 1);
      wr(80, 5);
      chk("t1_ign_fail", a_fail, 0);
      chk("t1_ign_mc", a_mc, 0);
      wr(84, 7);
      chk("t1_pass", a_pass, 1);
      chk("t1_mc", a_mc, 1);
      chk("t1_fail", a_fail, 0);
      chk("t1_done", a_done, 1);
      chk("t1_armed_lo", a_armed, 0);

      // strict: wrong write fails and captures the offender
      clr();
      load(84, 7);
      arm();
      chk("t2_pass_clr", a_pass, 0);
      wr(88, 3);
      chk("t2_fail", a_fail, 1);
      chk("t2_eadr", a_eadr, 88);
      chk("t2_edat", a_edat, 3);
      wr(84, 7);
      chk("t2_hold_fail", a_fail, 1);
      chk("t2_hold_pass", a_pass, 0);
      chk("t2_hold_mc", a_mc, 0);

      // timeout exactly 90 edges after the start edge
      arm();
      chk("t3_eadr_clr", a_eadr, 0);
      chk("t3_fail_clr", a_fail, 0);
      repeat (89) step();
      chk("t3_tmo_early", a_tmo, 0);
      chk("t3_armed_89", a_armed, 1);
      step();
      chk("t3_tmo", a_tmo, 1);
      chk("t3_armed_lo", a_armed, 0);
      // re-arm with a coincident write that must not be checked
      start = 1'b1; memwrite = 1'b1; dataadr = 88; writedata = 3;
      step();
      start = 1'b0; memwrite = 1'b0;
      chk("t3_rearm", a_armed, 1);
      chk("t3_tmo_clr", a_tmo, 0);
      chk("t3_startwr_fail", a_fail, 0);
      // exp_we while armed is ignored: table stays at one entry
      load(92, 9);
      wr(84, 7);
      chk("t3_pass", a_pass, 1);
      chk("t3_mc", a_mc, 1);

      // lenient ordering on instance b
      pulse_reset();
      chk("t4_rst_pass", b_pass, 0);
      load(64, 1);
      load(68, 2);
      load(72, 3);
      arm();
      wr(68, 2);
      chk("t4_mc0", b_mc, 0);
      wr(64, 1);
      chk("t4_mc1", b_mc, 1);
      wr(99, 9);
      chk("t4_skip_mc", b_mc, 1);
      chk("t4_skip_fail", b_fail, 0);
      wr(68, 2);
      chk("t4_mc2", b_mc, 2);
      wr(72, 3);
      chk("t4_pass", b_pass, 1);
      chk("t4_mc3", b_mc, 3);
      chk("t4_tmo", b_tmo, 0);

      // instance b, TIMEOUT 6: final match on the expiry edge wins
      clr();
      load(84, 7);
      arm();
      repeat (5) step();
      chk("t5_tmo_early", b_tmo, 0);
      wr(84, 7);
      chk("t5_pass", b_pass, 1);
      chk("t5_tmo", b_tmo, 0);
      arm();
      repeat (6) step();
      chk("t5_tmo_plain", b_tmo, 1);
      chk("t5_pass_plain", b_pass, 0);

      // depth limit and asynchronous reset mid-armed
      pulse_reset();
      load(64, 1);
      load(68, 2);
      load(72, 3);
      load(76, 4);
      load(84, 5);
      arm();
      wr(64, 1);
      wr(68, 2);
      wr(72, 3);
      chk("t6_mc3", a_mc, 3);
      chk("t6_pass_early", a_pass, 0);
      wr(76, 4);
      chk("t6_pass", a_pass, 1);
      chk("t6_mc4", a_mc, 4);
      arm();
      wr(64, 1);
      wr(68, 2);
      chk("t6_mc2", a_mc, 2);
      reset = 1'b1;
      #1;
      chk("t6_rst_armed", a_armed, 0);
      chk("t6_rst_mc", a_mc, 0);
      chk("t6_rst_done", a_done, 0);
      reset = 1'b0;
      step();
      arm();
      chk("t6_empty_start", a_armed, 0);
      chk("t6_empty_done", a_done, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
